// File: rtl/calc_pkg.sv
// Shared definitions for the calculator's arithmetic blocks: default operand
// width, arbiter state encoding and sign-magnitude field helpers.
package calc_pkg;

  localparam int MAG_W_DEFAULT = 2;
  localparam int SM_MAX_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Sign bit of a {sign, magnitude} value whose magnitude is mag_w bits wide.
  function automatic logic sm_sign(input logic [SM_MAX_W-1:0] v, input int mag_w);
    logic [SM_MAX_W-1:0] shifted;
    shifted = v >> mag_w;
    return shifted[0];
  endfunction

  function automatic logic [SM_MAX_W-1:0] sm_mag(input logic [SM_MAX_W-1:0] v, input int mag_w);
    return v & ((SM_MAX_W'(1) << mag_w) - SM_MAX_W'(1));
  endfunction

endpackage

// File: rtl/sm_mul_core.sv
// Combinational sign-magnitude multiplier: full-width product, sign
// normalisation (no negative zero) and zero/negative flags.
module sm_mul_core
  import calc_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEFAULT
) (
  input  logic [MAG_W:0]   i_a,
  input  logic [MAG_W:0]   i_b,
  output logic [2*MAG_W:0] o_result,
  output logic             o_zero,
  output logic             o_neg
);

  localparam int PW = 2 * MAG_W;

  logic             w_a_s;
  logic             w_b_s;
  logic [MAG_W-1:0] w_a_mag;
  logic [MAG_W-1:0] w_b_mag;
  logic [PW-1:0]    w_mag;
  logic             w_sign;

  always_comb begin
    w_a_s   = sm_sign(SM_MAX_W'(i_a), MAG_W);
    w_b_s   = sm_sign(SM_MAX_W'(i_b), MAG_W);
    w_a_mag = MAG_W'(sm_mag(SM_MAX_W'(i_a), MAG_W));
    w_b_mag = MAG_W'(sm_mag(SM_MAX_W'(i_b), MAG_W));
    w_mag   = PW'(w_a_mag) * PW'(w_b_mag);
    // A zero magnitude forces a positive sign, so -0 inputs collapse to +0.
    w_sign  = (w_a_s ^ w_b_s) & (w_mag != '0);
  end

  assign o_result = {w_sign, w_mag};
  assign o_zero   = (w_mag == '0);
  assign o_neg    = w_sign;

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude multiplier between N_REQ
// requesters: accept operands, compute for one cycle, hold the response.
module mul_arbiter
  import calc_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int MAG_W = MAG_W_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ*(MAG_W+1)-1:0]     req_a,
  input  logic [N_REQ*(MAG_W+1)-1:0]     req_b,
  output logic [N_REQ-1:0]               rsp_valid,
  input  logic [N_REQ-1:0]               rsp_ready,
  output logic [2*MAG_W:0]               rsp_result,
  output logic                           rsp_zero,
  output logic                           rsp_neg,
  output logic                           busy,
  output logic [$clog2(N_REQ)-1:0]       grant_id
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int OP_W  = MAG_W + 1;
  localparam int RES_W = 2 * MAG_W + 1;

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_grant_id;
  logic [OP_W-1:0]  r_op_a;
  logic [OP_W-1:0]  r_op_b;
  logic [RES_W-1:0] r_result;
  logic             r_zero;
  logic             r_neg;

  logic             w_found;
  logic [ID_W-1:0]  w_grant;
  logic             w_accept;
  logic             w_rsp_done;
  logic [N_REQ-1:0] w_req_ready;
  logic [N_REQ-1:0] w_rsp_valid;
  logic [RES_W-1:0] w_core_result;
  logic             w_core_zero;
  logic             w_core_neg;

  // Search starts one past the last served requester, wrapping around.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_grant = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_accept   = (r_state == IDLE) && w_found;
  assign w_rsp_done = (r_state == RESP) && rsp_ready[r_grant_id];

  // req_ready is also forced low while reset is held, even with valids pending.
  always_comb begin
    w_req_ready = '0;
    w_rsp_valid = '0;
    if (w_accept && rst_n) w_req_ready[w_grant] = 1'b1;
    if (r_state == RESP)   w_rsp_valid[r_grant_id] = 1'b1;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)   w_next_state = CALC;
      CALC:                    w_next_state = RESP;
      RESP:    if (w_rsp_done) w_next_state = IDLE;
      default:                 w_next_state = IDLE;
    endcase
  end

  sm_mul_core #(.MAG_W(MAG_W)) u_core (
    .i_a      (r_op_a),
    .i_b      (r_op_b),
    .o_result (w_core_result),
    .o_zero   (w_core_zero),
    .o_neg    (w_core_neg)
  );

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: all datapath registers are reset because their values are visible on outputs straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= ID_W'(N_REQ - 1);
      r_grant_id <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant_id <= w_grant;
        r_op_a     <= req_a[int'(w_grant)*OP_W +: OP_W];
        r_op_b     <= req_b[int'(w_grant)*OP_W +: OP_W];
      end
      if (r_state == CALC) begin
        r_result <= w_core_result;
        r_zero   <= w_core_zero;
        r_neg    <= w_core_neg;
      end
      if (w_rsp_done) r_rr_ptr <= r_grant_id;
    end
  end

  assign req_ready  = w_req_ready;
  assign rsp_valid  = w_rsp_valid;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_neg    = r_neg;
  assign busy       = (r_state != IDLE);
  assign grant_id   = r_grant_id;

endmodule
